// File: rtl/input_mapper.sv
// Maps PS/2 key events and two joypads onto registered arcade control lines.
// Each coin input is stretched into a fixed-length, vblank-timed pulse.
module input_mapper #(
  parameter int unsigned COIN_FRAMES = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        no_rotate,
  input  logic        vblank,
  output logic        p1_up,
  output logic        p1_down,
  output logic        p1_left,
  output logic        p1_right,
  output logic        p1_jump,
  output logic        p2_up,
  output logic        p2_down,
  output logic        p2_left,
  output logic        p2_right,
  output logic        p2_jump,
  output logic        start1,
  output logic        start2,
  output logic        coin1,
  output logic        coin2,
  output logic        test
);

  localparam logic [3:0] COIN_LIMIT = 4'(COIN_FRAMES);

  typedef enum logic [1:0] {
    COIN_IDLE,
    COIN_PULSE,
    COIN_HOLD
  } coin_state_e;

  typedef struct packed {
    logic up1, down1, left1, right1;
    logic space, ctrl;
    logic f1, f2, key1, key2, key5, key6;
    logic up2, down2, left2, right2, jump2;
    logic test;
  } held_t;

  held_t       held_q;
  logic        toggle_q;
  logic        armed_q;
  logic        vblank_q;
  logic        key_event;
  logic        key_pressed;
  logic        key_ext;
  logic [7:0]  key_code;
  logic        vblank_rise;

  coin_state_e coin_state_q [2];
  coin_state_e coin_state_d [2];
  logic [3:0]  coin_cnt_q   [2];
  logic [3:0]  coin_cnt_d   [2];
  logic [1:0]  coin_raw;

  logic p1_raw_up, p1_raw_down, p1_raw_left, p1_raw_right, p1_raw_jump;
  logic p2_raw_up, p2_raw_down, p2_raw_left, p2_raw_right, p2_raw_jump;
  logic unused_pad_bits;

  assign key_code    = ps2_key[7:0];
  assign key_ext     = ps2_key[8];
  assign key_pressed = ps2_key[9];
  assign key_event   = armed_q & (ps2_key[10] != toggle_q);
  assign vblank_rise = vblank & ~vblank_q;

  assign unused_pad_bits = ^{joystick_0[15:8], joystick_1[15:8]};

  // Toggle tracking and arming. armed_q keeps a stale toggle level present
  // at reset release from being mistaken for a key event.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of process ordering.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= 1'b0;
      armed_q  <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      toggle_q <= ps2_key[10];
      armed_q  <= 1'b1;
      vblank_q <= vblank;
    end
  end

  // Held-key registers: arrow keys match either extended flag, all others
  // only the non-extended code.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      held_q <= '0;
    end else if (key_event) begin
      case (key_code)
        8'h75: held_q.up1    <= key_pressed;
        8'h72: held_q.down1  <= key_pressed;
        8'h6B: held_q.left1  <= key_pressed;
        8'h74: held_q.right1 <= key_pressed;
        default: begin
          if (!key_ext) begin
            case (key_code)
              8'h29: held_q.space  <= key_pressed;
              8'h14: held_q.ctrl   <= key_pressed;
              8'h05: held_q.f1     <= key_pressed;
              8'h06: held_q.f2     <= key_pressed;
              8'h16: held_q.key1   <= key_pressed;
              8'h1E: held_q.key2   <= key_pressed;
              8'h2E: held_q.key5   <= key_pressed;
              8'h36: held_q.key6   <= key_pressed;
              8'h2D: held_q.up2    <= key_pressed;
              8'h2B: held_q.down2  <= key_pressed;
              8'h23: held_q.left2  <= key_pressed;
              8'h34: held_q.right2 <= key_pressed;
              8'h1C: held_q.jump2  <= key_pressed;
              8'h2C: held_q.test   <= key_pressed;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign p1_raw_up    = held_q.up1    | joystick_0[3];
  assign p1_raw_down  = held_q.down1  | joystick_0[2];
  assign p1_raw_left  = held_q.left1  | joystick_0[1];
  assign p1_raw_right = held_q.right1 | joystick_0[0];
  assign p1_raw_jump  = held_q.space  | held_q.ctrl | joystick_0[4];

  assign p2_raw_up    = held_q.up2    | joystick_1[3];
  assign p2_raw_down  = held_q.down2  | joystick_1[2];
  assign p2_raw_left  = held_q.left2  | joystick_1[1];
  assign p2_raw_right = held_q.right2 | joystick_1[0];
  assign p2_raw_jump  = held_q.jump2  | joystick_1[4];

  assign coin_raw[0] = held_q.key5 | joystick_0[7];
  assign coin_raw[1] = held_q.key6 | joystick_1[7];

  // Coin pulse stretchers. The counter is cleared on entry to PULSE, so a
  // vblank edge landing on that same clock is not counted.
  // NOTE: every variable gets its default before the case so that no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      coin_state_d[i] = coin_state_q[i];
      coin_cnt_d[i]   = coin_cnt_q[i];
      case (coin_state_q[i])
        COIN_IDLE: begin
          if (coin_raw[i] && armed_q) begin
            coin_state_d[i] = COIN_PULSE;
            coin_cnt_d[i]   = '0;
          end
        end
        COIN_PULSE: begin
          if (vblank_rise) begin
            coin_cnt_d[i] = coin_cnt_q[i] + 4'd1;
            if (coin_cnt_q[i] + 4'd1 == COIN_LIMIT) coin_state_d[i] = COIN_HOLD;
          end
        end
        COIN_HOLD: begin
          if (!coin_raw[i]) coin_state_d[i] = COIN_IDLE;
        end
        default: coin_state_d[i] = COIN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        coin_state_q[i] <= COIN_IDLE;
        coin_cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        coin_state_q[i] <= coin_state_d[i];
        coin_cnt_q[i]   <= coin_cnt_d[i];
      end
    end
  end

  // Output registers; a horizontal cabinet rotates each player's directions.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      p1_up    <= 1'b0;
      p1_down  <= 1'b0;
      p1_left  <= 1'b0;
      p1_right <= 1'b0;
      p1_jump  <= 1'b0;
      p2_up    <= 1'b0;
      p2_down  <= 1'b0;
      p2_left  <= 1'b0;
      p2_right <= 1'b0;
      p2_jump  <= 1'b0;
      start1   <= 1'b0;
      start2   <= 1'b0;
      coin1    <= 1'b0;
      coin2    <= 1'b0;
      test     <= 1'b0;
    end else begin
      p1_up    <= no_rotate ? p1_raw_left  : p1_raw_up;
      p1_down  <= no_rotate ? p1_raw_right : p1_raw_down;
      p1_left  <= no_rotate ? p1_raw_down  : p1_raw_left;
      p1_right <= no_rotate ? p1_raw_up    : p1_raw_right;
      p1_jump  <= p1_raw_jump;
      p2_up    <= no_rotate ? p2_raw_left  : p2_raw_up;
      p2_down  <= no_rotate ? p2_raw_right : p2_raw_down;
      p2_left  <= no_rotate ? p2_raw_down  : p2_raw_left;
      p2_right <= no_rotate ? p2_raw_up    : p2_raw_right;
      p2_jump  <= p2_raw_jump;
      start1   <= held_q.f1 | held_q.key1 | joystick_0[5] | joystick_1[5];
      start2   <= held_q.f2 | held_q.key2 | joystick_0[6] | joystick_1[6];
      test     <= held_q.test;
      coin1    <= (coin_state_d[0] == COIN_PULSE);
      coin2    <= (coin_state_d[1] == COIN_PULSE);
    end
  end

endmodule

// File: tb/tb_input_mapper.sv
// Randomised and scenario-driven bench for input_mapper against a
// cycle-level behavioural model of the key, pad and coin rules.
module tb_input_mapper;

  localparam int COIN_FRAMES = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [15:0] joystick_0 = '0;
  logic [15:0] joystick_1 = '0;
  logic        no_rotate = 1'b0;
  logic        vblank = 1'b0;
  logic p1_up, p1_down, p1_left, p1_right, p1_jump;
  logic p2_up, p2_down, p2_left, p2_right, p2_jump;
  logic start1, start2, coin1, coin2, test;

  input_mapper #(.COIN_FRAMES(COIN_FRAMES)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .no_rotate(no_rotate), .vblank(vblank),
    .p1_up(p1_up), .p1_down(p1_down), .p1_left(p1_left), .p1_right(p1_right), .p1_jump(p1_jump),
    .p2_up(p2_up), .p2_down(p2_down), .p2_left(p2_left), .p2_right(p2_right), .p2_jump(p2_jump),
    .start1(start1), .start2(start2), .coin1(coin1), .coin2(coin2), .test(test)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int K_UP1 = 0, K_DN1 = 1, K_LF1 = 2, K_RT1 = 3, K_SPACE = 4, K_CTRL = 5,
                 K_F1 = 6, K_F2 = 7, K_KEY1 = 8, K_KEY2 = 9, K_KEY5 = 10, K_KEY6 = 11,
                 K_UP2 = 12, K_DN2 = 13, K_LF2 = 14, K_RT2 = 15, K_JMP2 = 16, K_TEST = 17;

  bit         held [18];
  bit         m_armed, m_tog, m_vb;
  int         m_left [2];
  bit         m_wait [2];
  logic [4:0] exp_p1, exp_p2, exp_sys;

  function automatic int key_index(input logic [7:0] code, input logic ext);
    case (code)
      8'h75: return K_UP1;
      8'h72: return K_DN1;
      8'h6B: return K_LF1;
      8'h74: return K_RT1;
      default: ;
    endcase
    if (ext) return -1;
    case (code)
      8'h29: return K_SPACE;
      8'h14: return K_CTRL;
      8'h05: return K_F1;
      8'h06: return K_F2;
      8'h16: return K_KEY1;
      8'h1E: return K_KEY2;
      8'h2E: return K_KEY5;
      8'h36: return K_KEY6;
      8'h2D: return K_UP2;
      8'h2B: return K_DN2;
      8'h23: return K_LF2;
      8'h34: return K_RT2;
      8'h1C: return K_JMP2;
      8'h2C: return K_TEST;
      default: return -1;
    endcase
  endfunction

  function automatic logic [4:0] player(input bit u, input bit d, input bit l, input bit r,
                                        input bit j, input bit rot);
    if (rot) return {l, r, d, u, j};
    return {u, d, l, r, j};
  endfunction

  task automatic model_reset();
    foreach (held[k]) held[k] = 1'b0;
    m_armed = 0; m_tog = 0; m_vb = 0;
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0;
      m_wait[i] = 0;
    end
    exp_p1 = '0; exp_p2 = '0; exp_sys = '0;
  endtask

  // One rising edge, using the input values present just before it.
  task automatic model_step();
    bit raw [2];
    bit rise;
    int k;
    exp_p1 = player(held[K_UP1] | joystick_0[3], held[K_DN1] | joystick_0[2],
                    held[K_LF1] | joystick_0[1], held[K_RT1] | joystick_0[0],
                    held[K_SPACE] | held[K_CTRL] | joystick_0[4], no_rotate);
    exp_p2 = player(held[K_UP2] | joystick_1[3], held[K_DN2] | joystick_1[2],
                    held[K_LF2] | joystick_1[1], held[K_RT2] | joystick_1[0],
                    held[K_JMP2] | joystick_1[4], no_rotate);
    raw[0] = held[K_KEY5] | joystick_0[7];
    raw[1] = held[K_KEY6] | joystick_1[7];
    rise = vblank && !m_vb;
    for (int i = 0; i < 2; i++) begin
      if (m_left[i] > 0) begin
        if (rise) begin
          m_left[i]--;
          if (m_left[i] == 0) m_wait[i] = 1;
        end
      end else if (m_wait[i]) begin
        if (!raw[i]) m_wait[i] = 0;
      end else if (raw[i] && m_armed) begin
        m_left[i] = COIN_FRAMES;
      end
    end
    exp_sys = {held[K_F1] | held[K_KEY1] | joystick_0[5] | joystick_1[5],
               held[K_F2] | held[K_KEY2] | joystick_0[6] | joystick_1[6],
               m_left[0] > 0, m_left[1] > 0, held[K_TEST]};
    if (m_armed && (ps2_key[10] != m_tog)) begin
      k = key_index(ps2_key[7:0], ps2_key[8]);
      if (k >= 0) held[k] = ps2_key[9];
    end
    m_armed = 1;
    m_tog   = ps2_key[10];
    m_vb    = vblank;
  endtask

  // ---------------- stimulus helpers ----------------
  int cyc = 0;
  bit vb_en = 1;
  bit prev_c1, prev_c2;
  int pulses1, pulses2, hi1;

  task automatic clear_counts();
    pulses1 = 0; pulses2 = 0; hi1 = 0;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    if (!reset_n) model_reset();
    else model_step();
    @(negedge clk_sys);
    check("p1", {p1_up, p1_down, p1_left, p1_right, p1_jump}, exp_p1);
    check("p2", {p2_up, p2_down, p2_left, p2_right, p2_jump}, exp_p2);
    check("sys", {start1, start2, coin1, coin2, test}, exp_sys);
    if (coin1 && !prev_c1) pulses1++;
    if (coin2 && !prev_c2) pulses2++;
    if (coin1) hi1++;
    prev_c1 = coin1;
    prev_c2 = coin2;
    cyc++;
    if (vb_en) vblank = (cyc % 6) < 2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_key(input logic [7:0] code, input logic ext, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    tick();
  endtask

  function automatic logic [14:0] all_outs();
    return {p1_up, p1_down, p1_left, p1_right, p1_jump, p2_up, p2_down, p2_left, p2_right,
            p2_jump, start1, start2, coin1, coin2, test};
  endfunction

  logic [7:0] codes [20] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h06, 8'h16,
                             8'h1E, 8'h2E, 8'h36, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h2C,
                             8'h1A, 8'h44};

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    model_reset();
    @(negedge clk_sys);
    ticks(3);
    check("reset_outs", all_outs(), '0);

    // Stale toggle level at reset release must not register as an event.
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("quiet_after_reset", all_outs(), '0);
    end

    // Arrow key with and without the extended flag, then rotated.
    send_key(8'h75, 1'b1, 1'b1);
    check("up_edge1", p1_up, 1'b0);
    send_key(8'h75, 1'b0, 1'b1);
    check("up_edge2", p1_up, 1'b1);
    send_key(8'h75, 1'b0, 1'b0);
    tick();
    check("up_release", p1_up, 1'b0);
    no_rotate = 1'b1;
    tick();
    send_key(8'h75, 1'b1, 1'b1);
    tick();
    check("rot_right", {p1_right, p1_up}, 2'b10);
    send_key(8'h75, 1'b1, 1'b0);
    tick();
    check("rot_right_rel", p1_right, 1'b0);
    no_rotate = 1'b0;

    // Space and ctrl as independent jump sources.
    send_key(8'h29, 1'b0, 1'b1);
    send_key(8'h14, 1'b0, 1'b1);
    send_key(8'h29, 1'b0, 1'b0);
    tick();
    check("jump_held", p1_jump, 1'b1);
    send_key(8'h14, 1'b0, 1'b0);
    check("jump_edge1", p1_jump, 1'b1);
    tick();
    check("jump_released", p1_jump, 1'b0);

    // Held pad coin: exactly one pulse, then a second after re-press.
    clear_counts();
    joystick_0[7] = 1'b1;
    ticks(120);
    check("coin1_one_pulse", pulses1, 1);
    check("coin1_len_ok", (hi1 >= 19 && hi1 <= 24), 1'b1);
    joystick_0[7] = 1'b0;
    ticks(5);
    joystick_0[7] = 1'b1;
    ticks(40);
    check("coin1_second_pulse", pulses1, 2);
    joystick_0[7] = 1'b0;
    ticks(5);

    // Tapped key5 alongside a simultaneous pad coin on player 2.
    clear_counts();
    joystick_1[7] = 1'b1;
    send_key(8'h2E, 1'b0, 1'b1);
    ticks(6);
    joystick_1[7] = 1'b0;
    send_key(8'h2E, 1'b0, 1'b0);
    ticks(40);
    check("coin1_tap_pulse", pulses1, 1);
    check("coin2_pulse", pulses2, 1);
    check("coin1_tap_len", (hi1 >= 19 && hi1 <= 24), 1'b1);

    // Reset in the middle of a pulse, raw coin still held across it.
    joystick_0[7] = 1'b1;
    waited = 0;
    while (!coin1 && waited < 50) begin
      tick();
      waited++;
    end
    check("coin1_start_timeout", waited < 50, 1'b1);
    ticks(12);
    check("coin1_mid", coin1, 1'b1);
    reset_n = 1'b0;
    #1;
    check("coin1_async_clear", coin1, 1'b0);
    model_reset();
    @(negedge clk_sys);
    ticks(2);
    reset_n = 1'b1;
    tick();
    check("coin1_arming", coin1, 1'b0);
    tick();
    check("coin1_repulse", coin1, 1'b1);
    joystick_0[7] = 1'b0;
    ticks(30);

    // Randomised traffic on every channel.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 2) == 0)
        ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                   codes[$urandom_range(0, 19)]};
      if ($urandom_range(0, 3) == 0) joystick_0[6:0] = 7'($urandom);
      if ($urandom_range(0, 3) == 0) joystick_1[6:0] = 7'($urandom);
      if ($urandom_range(0, 7) == 0) joystick_0[15:8] = 8'($urandom);
      if ($urandom_range(0, 7) == 0) joystick_1[15:8] = 8'($urandom);
      if ($urandom_range(0, 40) == 0) joystick_0[7] = ~joystick_0[7];
      if ($urandom_range(0, 40) == 0) joystick_1[7] = ~joystick_1[7];
      if ($urandom_range(0, 60) == 0) no_rotate = ~no_rotate;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
